oled_spi_arbiter: RTL and testbench

//  Shares the single PmodOLED SPI controller (SpiCtrl: SPI_EN/SPI_DATA/SPI_FIN) among NREQ requesters
//  (e.g. power-up init sequencer, screen updater, debug writer). It arbitrates round-robin per byte and

---
 rtl/oled_spi_arbiter.sv | 157 +++++++++++++++
 tb/tb_oled_spi_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter sharing one PmodOLED SpiCtrl among NREQ byte requesters.
// Each grant moves one byte; a requester holding LOCK keeps the bus across bytes.
module oled_spi_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    LOCK,
  input  logic [NREQ-1:0]    DC_IN,
  input  logic [NREQ*DW-1:0] DATA_IN,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    ACK,
  output logic               BUSY,
  output logic               DC,
  output logic               SPI_EN,
  output logic [DW-1:0]      SPI_DATA,
  input  logic               SPI_FIN
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StRelease,
    StWaitLow
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          lock_q, lock_d;
  logic          dc_q, dc_d;
  logic [DW-1:0] data_q, data_d;

  logic [IW-1:0] pick_hi, pick_lo, pick;
  logic          hi_vld, lo_vld;
  logic [IW-1:0] next_ptr;
  logic          load;
  logic [IW-1:0] load_sel;

  // Round-robin pick: first request at or above rr_ptr, else the lowest one (wrap).
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (REQ[j] && !lo_vld) begin
        lo_vld  = 1'b1;
        pick_lo = IW'(j);
      end
      if (REQ[j] && !hi_vld && (j >= 32'(rr_ptr_q))) begin
        hi_vld  = 1'b1;
        pick_hi = IW'(j);
      end
    end
    pick = hi_vld ? pick_hi : pick_lo;
  end

  // Pointer just past the current owner, modulo NREQ.
  always_comb begin
    next_ptr = owner_q + 1'b1;
    if (owner_q == IW'(NREQ - 1)) begin
      next_ptr = '0;
    end
  end

  // Next-state logic; requester inputs are captured only when entering SETUP.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    dc_d     = dc_q;
    data_d   = data_q;
    load     = 1'b0;
    load_sel = owner_q;

    unique case (state_q)
      StIdle: begin
        if (lo_vld) begin
          load     = 1'b1;
          load_sel = pick;
          state_d  = StSetup;
        end
      end
      StSetup:   state_d = StXfer;
      StXfer: begin
        // A FIN already high on entry is taken as completion.
        if (SPI_FIN) begin
          state_d = StRelease;
        end
      end
      StRelease: state_d = StWaitLow;
      StWaitLow: begin
        if (!SPI_FIN) begin
          if (lock_q && REQ[owner_q]) begin
            load    = 1'b1;
            state_d = StSetup;
          end else begin
            rr_ptr_d = next_ptr;
            state_d  = StIdle;
          end
        end
      end
      default:   state_d = StIdle;
    endcase

    if (load) begin
      owner_d = load_sel;
      data_d  = DATA_IN[32'(load_sel)*DW +: DW];
      dc_d    = DC_IN[load_sel];
      lock_d  = LOCK[load_sel];
    end
  end

  // State and latched byte registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      dc_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
      dc_q     <= dc_d;
      data_q   <= data_d;
    end
  end

  // Grant/ack decode; state-derived so reset clears them immediately.
  always_comb begin
    GNT = '0;
    ACK = '0;
    if (state_q != StIdle) begin
      GNT[owner_q] = 1'b1;
    end
    if (state_q == StRelease) begin
      ACK[owner_q] = 1'b1;
    end
  end

  assign BUSY     = (state_q != StIdle);
  assign SPI_EN   = (state_q == StXfer);
  assign DC       = dc_q;
  assign SPI_DATA = data_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Randomized bench for oled_spi_arbiter: requester queues, a SpiCtrl model and a
// transaction-level reference for grant order, locking and handshake timing.
module tb_oled_spi_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 8;

  typedef logic [9:0] ent_t;  // {lock, dc, data}

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N-1:0]    REQ = '0;
  logic [N-1:0]    LOCK = '0;
  logic [N-1:0]    DC_IN = '0;
  logic [N*DW-1:0] DATA_IN = '0;
  logic [N-1:0]    GNT, ACK;
  logic            BUSY, DC, SPI_EN;
  logic [DW-1:0]   SPI_DATA;
  logic            SPI_FIN = 1'b0;

  oled_spi_arbiter #(.NREQ(N), .DW(DW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .LOCK     (LOCK),
    .DC_IN    (DC_IN),
    .DATA_IN  (DATA_IN),
    .GNT      (GNT),
    .ACK      (ACK),
    .BUSY     (BUSY),
    .DC       (DC),
    .SPI_EN   (SPI_EN),
    .SPI_DATA (SPI_DATA),
    .SPI_FIN  (SPI_FIN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int n_bytes  = 0;

  // Requester model
  ent_t         rq [N][$];
  logic [N-1:0] dropped = '0;
  int           drop_mode = 0;  // 0 never, 1 always, 2 random
  // SpiCtrl model
  logic fin = 1'b0, fin_acked = 1'b0;
  int   fin_cnt = 0, fin_hold = 0;
  int   lat_lo = 2, lat_hi = 2, early_pct = 0;
  // Reference state
  int           rr = 0;
  logic         in_wait = 1'b0, wait_lock = 1'b0, prev_rose = 1'b0;
  int           age = 0, wait_owner = 0;
  logic [N-1:0] prev_req = '0, prev_gnt = '0;
  logic         prev_en = 1'b0, prev_fin = 1'b0, prev_dc = 1'b0;
  logic [7:0]   prev_data = '0;
  int           owner_log[$];
  int           dc_log[$];
  int           exp2[4] = '{0, 1, 0, 1};
  int           exp3[7] = '{0, 1, 1, 1, 1, 0, 0};
  int           b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  // First requesting index searching upward from p, wrapping.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] res;
    res = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (res == 0 && r[(p + k) % int'(N)]) res[(p + k) % int'(N)] = 1'b1;
    end
    return res;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < int'(N); i++) if (rq[i].size() != 0) return 1'b1;
    return BUSY || fin || in_wait;
  endfunction

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      if (rq[i].size() != 0) begin
        REQ[i]          = !dropped[i];
        LOCK[i]         = rq[i][0][9];
        DC_IN[i]        = rq[i][0][8];
        DATA_IN[i*8 +: 8] = rq[i][0][7:0];
      end else begin
        REQ[i]          = 1'b0;
        LOCK[i]         = 1'($urandom);
        DC_IN[i]        = 1'($urandom);
        DATA_IN[i*8 +: 8] = 8'($urandom);
      end
    end
    SPI_FIN = fin;
  endtask

  task automatic present();
    drive();
    prev_req = REQ;
  endtask

  task automatic step();
    bit is_setup;
    int own;
    bit ok;
    @(posedge CLK);
    #1;
    is_setup = 1'b0;
    if (in_wait) age++;
    check_eq("gnt_onehot0", 32'($onehot0(GNT)), 32'd1);
    check_eq("busy_vs_gnt", 32'(BUSY), 32'(GNT != 0));
    // Byte completion: ACK exactly one cycle after FIN seen during XFER
    if (prev_en && prev_fin) begin
      check_eq("ack_owner", 32'(ACK), 32'(prev_gnt));
      check_eq("en_after_fin", 32'(SPI_EN), 32'd0);
    end else begin
      check_eq("ack_spurious", 32'(ACK), 32'd0);
      if (prev_en) check_eq("en_hold", 32'(SPI_EN), 32'd1);
    end
    if (SPI_EN && prev_en) begin
      check_eq("xfer_data_stable", 32'(SPI_DATA), 32'(prev_data));
      check_eq("xfer_dc_stable", 32'(DC), 32'(prev_dc));
    end
    if (SPI_EN && !prev_en) begin
      check_eq("en_gnt_stable", 32'(GNT), 32'(prev_gnt));
      check_eq("dc_before_en", 32'(DC), 32'(prev_dc));
      check_eq("data_before_en", 32'(SPI_DATA), 32'(prev_data));
      own = idx_of(GNT);
      ok  = (own >= 0) ? (rq[own].size() != 0) : 1'b0;
      check_eq("byte_source", 32'(ok), 32'd1);
      if (ok) begin
        check_eq("byte_data", 32'(SPI_DATA), 32'(rq[own][0][7:0]));
        check_eq("byte_dc", 32'(DC), 32'(rq[own][0][8]));
        owner_log.push_back(own);
        dc_log.push_back(int'(DC));
      end
    end
    if (prev_rose) check_eq("en_latency", 32'(SPI_EN), 32'd1);
    // Arbitration out of IDLE
    if (prev_gnt == 0) begin
      check_eq("arb_pick", 32'(GNT), 32'(rr_pick(prev_req, rr)));
      if (GNT != 0) begin
        is_setup = 1'b1;
        check_eq("setup_en_low", 32'(SPI_EN), 32'd0);
      end
    end
    // Leaving the wait-for-FIN-low phase: keep (locked) or release
    if (in_wait && age >= 2 && !prev_fin) begin
      if (wait_lock && prev_req[wait_owner]) begin
        check_eq("lock_keep", 32'(GNT), 32'(oh(wait_owner)));
        check_eq("lock_setup_en", 32'(SPI_EN), 32'd0);
        is_setup = 1'b1;
      end else begin
        check_eq("release", 32'(GNT), 32'd0);
        rr = (wait_owner + 1) % int'(N);
      end
      in_wait = 1'b0;
    end else if (in_wait && age >= 1) begin
      check_eq("wait_gnt", 32'(GNT), 32'(oh(wait_owner)));
      check_eq("wait_en_low", 32'(SPI_EN), 32'd0);
    end
    if (DC !== prev_dc) check_eq("dc_change_setup", 32'(is_setup), 32'd1);
    if (SPI_DATA !== prev_data) check_eq("data_change_setup", 32'(is_setup), 32'd1);
    // Requester side of the ACK
    if (ACK != 0) begin
      own = idx_of(ACK);
      ok  = (own >= 0) ? (rq[own].size() != 0) : 1'b0;
      check_eq("ack_has_byte", 32'(ok), 32'd1);
      if (ok) begin
        in_wait    = 1'b1;
        age        = 0;
        wait_owner = own;
        wait_lock  = rq[own][0][9];
        void'(rq[own].pop_front());
        dropped[own] = 1'b0;
        n_bytes++;
      end
    end
    // Requester abandons REQ mid-transfer on its last byte
    if (drop_mode != 0 && SPI_EN) begin
      own = idx_of(GNT);
      if (own >= 0 && rq[own].size() == 1 && (drop_mode == 1 || $urandom_range(0, 2) == 0))
        dropped[own] = 1'b1;
    end
    // SpiCtrl model
    if (fin) begin
      if (ACK != 0) fin_acked = 1'b1;
      if (fin_acked && !SPI_EN) begin
        if (fin_hold == 0) begin
          fin       = 1'b0;
          fin_acked = 1'b0;
        end else begin
          fin_hold--;
        end
      end
    end else if (SPI_EN) begin
      if (fin_cnt == 0) begin
        fin      = 1'b1;
        fin_hold = $urandom_range(0, 2);
      end else begin
        fin_cnt--;
      end
    end else if (is_setup) begin
      fin_cnt = $urandom_range(lat_lo, lat_hi);
      if ($urandom_range(0, 99) < early_pct) begin
        fin      = 1'b1;
        fin_hold = $urandom_range(0, 2);
      end
    end
    prev_rose = is_setup;
    drive();
    prev_req  = REQ;
    prev_gnt  = GNT;
    prev_en   = SPI_EN;
    prev_fin  = fin;
    prev_dc   = DC;
    prev_data = SPI_DATA;
  endtask

  task automatic apply_reset(input int cycles);
    RST = 1'b0;
    for (int i = 0; i < int'(N); i++) rq[i].delete();
    dropped   = '0;
    fin       = 1'b0;
    fin_acked = 1'b0;
    in_wait   = 1'b0;
    prev_rose = 1'b0;
    rr        = 0;
    drive();
    repeat (cycles) @(posedge CLK);
    #1;
    check_eq("rst_gnt", 32'(GNT), 32'd0);
    check_eq("rst_ack", 32'(ACK), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_en", 32'(SPI_EN), 32'd0);
    check_eq("rst_dc", 32'(DC), 32'd0);
    check_eq("rst_data", 32'(SPI_DATA), 32'd0);
    RST       = 1'b1;
    prev_req  = REQ;
    prev_gnt  = '0;
    prev_en   = 1'b0;
    prev_fin  = 1'b0;
    prev_dc   = 1'b0;
    prev_data = '0;
  endtask

  task automatic run_drain(input int limit);
    int c;
    c = 0;
    while (pending() && c < limit) begin
      step();
      c++;
    end
    check_eq("drain_in_time", 32'(!pending()), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset(3);

    // Single requester, FIN after 20 cycles
    lat_lo = 20;
    lat_hi = 20;
    owner_log.delete();
    b0 = n_bytes;
    rq[0].push_back({1'b0, 1'b0, 8'h22});
    present();
    step();
    check_eq("t1_gnt", 32'(GNT), 32'h1);
    check_eq("t1_dc", 32'(DC), 32'd0);
    check_eq("t1_data", 32'(SPI_DATA), 32'h22);
    check_eq("t1_en_low", 32'(SPI_EN), 32'd0);
    step();
    check_eq("t1_en", 32'(SPI_EN), 32'd1);
    run_drain(200);
    check_eq("t1_bytes", 32'(n_bytes - b0), 32'd1);
    // Pointer moved past requester 0
    lat_lo = 1;
    lat_hi = 4;
    owner_log.delete();
    rq[0].push_back({1'b0, 1'b0, 8'hA5});
    rq[1].push_back({1'b0, 1'b1, 8'h5A});
    present();
    run_drain(200);
    check_eq("t1_rr_next", 32'((owner_log.size() > 0) ? owner_log[0] : -1), 32'd1);

    // Simultaneous requests from reset alternate
    apply_reset(2);
    owner_log.delete();
    for (int k = 0; k < 2; k++) begin
      rq[0].push_back({1'b0, 1'b0, 8'(8'h10 + k)});
      rq[1].push_back({1'b0, 1'b1, 8'(8'h20 + k)});
    end
    present();
    run_drain(400);
    check_eq("t2_count", 32'(owner_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < owner_log.size(); k++) check_eq("t2_order", 32'(owner_log[k]), 32'(exp2[k]));

    // Locked 4-byte burst from req1 against continuous req0
    owner_log.delete();
    rq[1].push_back({1'b1, 1'b0, 8'h22});
    rq[1].push_back({1'b1, 1'b0, 8'h00});
    rq[1].push_back({1'b1, 1'b0, 8'h00});
    rq[1].push_back({1'b0, 1'b0, 8'h10});
    for (int k = 0; k < 3; k++) rq[0].push_back({1'b0, 1'b1, 8'(8'h40 + k)});
    present();
    run_drain(600);
    check_eq("t3_count", 32'(owner_log.size()), 32'd7);
    for (int k = 0; k < 7 && k < owner_log.size(); k++) check_eq("t3_order", 32'(owner_log[k]), 32'(exp3[k]));

    // Requester 0 drops REQ mid-transfer on a locked byte
    drop_mode = 1;
    lat_lo    = 6;
    lat_hi    = 6;
    owner_log.delete();
    b0 = n_bytes;
    rq[0].push_back({1'b1, 1'b0, 8'h77});
    present();
    run_drain(200);
    check_eq("t4_bytes", 32'(n_bytes - b0), 32'd1);
    check_eq("t4_idle", 32'(BUSY), 32'd0);
    drop_mode = 0;

    // Reset in XFER
    rq[0].push_back({1'b1, 1'b0, 8'h3C});
    lat_lo = 30;
    lat_hi = 30;
    present();
    for (int c = 0; c < 20 && !SPI_EN; c++) step();
    check_eq("t5_in_xfer", 32'(SPI_EN), 32'd1);
    b0 = n_bytes;
    #2;
    RST = 1'b0;
    #1;
    check_eq("t5_en_async", 32'(SPI_EN), 32'd0);
    check_eq("t5_gnt_async", 32'(GNT), 32'd0);
    check_eq("t5_busy_async", 32'(BUSY), 32'd0);
    check_eq("t5_ack_async", 32'(ACK), 32'd0);
    apply_reset(2);
    check_eq("t5_no_ack", 32'(n_bytes - b0), 32'd0);
    lat_lo = 2;
    lat_hi = 5;
    owner_log.delete();
    rq[1].push_back({1'b0, 1'b1, 8'h99});
    present();
    step();
    check_eq("t5_gnt_req1", 32'(GNT), 32'h2);
    run_drain(200);
    check_eq("t5_owner", 32'((owner_log.size() > 0) ? owner_log[0] : -1), 32'd1);

    // DC switch inside a locked pair
    dc_log.delete();
    rq[0].push_back({1'b1, 1'b0, 8'hAF});
    rq[0].push_back({1'b0, 1'b1, 8'h55});
    present();
    run_drain(200);
    check_eq("t6_count", 32'(dc_log.size()), 32'd2);
    if (dc_log.size() == 2) begin
      check_eq("t6_dc0", 32'(dc_log[0]), 32'd0);
      check_eq("t6_dc1", 32'(dc_log[1]), 32'd1);
    end

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      lat_lo    = $urandom_range(0, 3);
      lat_hi    = lat_lo + $urandom_range(0, 8);
      early_pct = ($urandom_range(0, 2) == 0) ? 30 : 0;
      drop_mode = ($urandom_range(0, 2) == 0) ? 2 : 0;
      for (int i = 0; i < int'(N); i++) begin
        int nb;
        nb = $urandom_range(0, 5);
        for (int k = 0; k < nb; k++) rq[i].push_back(ent_t'($urandom));
        present();
        repeat ($urandom_range(0, 30)) step();
      end
      run_drain(3000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
